// File: rtl/conv_kxk_weight_bank.sv
// Weight bank for a KxK convolution engine: collects serial taps into sets and
// serves whole sets to the MAC array in FIFO or round-robin replay order.
module conv_kxk_weight_bank #(
  parameter int DATA_WIDTH     = 32,
  parameter int KERNEL_SIZE    = 9,
  parameter int TAP_CNT_WIDTH  = 4,
  parameter int NUM_SETS       = 4,
  parameter int SET_ADDR_WIDTH = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              valid_in,
  input  logic [DATA_WIDTH-1:0]             in,
  output logic                              in_ready,
  input  logic                              load_weights,
  input  logic                              replay_mode,
  output logic [KERNEL_SIZE*DATA_WIDTH-1:0] weights_out,
  output logic                              valid_out,
  output logic                              load_err,
  output logic [SET_ADDR_WIDTH:0]           set_count,
  output logic                              full,
  output logic                              empty
);

  localparam int SET_W = KERNEL_SIZE * DATA_WIDTH;
  localparam int CNT_W = SET_ADDR_WIDTH + 1;
  localparam logic [TAP_CNT_WIDTH-1:0]  LAST_TAP = TAP_CNT_WIDTH'(KERNEL_SIZE - 1);
  localparam logic [TAP_CNT_WIDTH-1:0]  TAP_ONE  = TAP_CNT_WIDTH'(1);
  localparam logic [SET_ADDR_WIDTH-1:0] PTR_ONE  = SET_ADDR_WIDTH'(1);
  localparam logic [CNT_W-1:0]          CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]          FULL_CNT = CNT_W'(NUM_SETS);

  logic [TAP_CNT_WIDTH-1:0]  tap_cnt_q, tap_cnt_d;
  logic [SET_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [SET_ADDR_WIDTH-1:0] head_q, head_d;
  logic [SET_ADDR_WIDTH-1:0] offset_q, offset_d;
  logic [CNT_W-1:0]          set_count_q, set_count_d;
  logic [DATA_WIDTH-1:0]     coll_q [KERNEL_SIZE-1];
  logic [DATA_WIDTH-1:0]     coll_d [KERNEL_SIZE-1];
  logic [SET_W-1:0]          bank_q [NUM_SETS];
  logic [SET_W-1:0]          bank_d [NUM_SETS];
  logic [SET_W-1:0]          weights_q, weights_d;
  logic                      valid_q, valid_d;
  logic                      load_err_q, load_err_d;
  logic                      mode_q, mode_d;

  logic                      accept, commit, do_load, pop;
  logic [SET_ADDR_WIDTH-1:0] eff_offset, rd_idx;
  logic [SET_W-1:0]          commit_set;

  assign full        = (set_count_q == FULL_CNT);
  assign empty       = (set_count_q == '0);
  assign in_ready    = ~full;
  assign set_count   = set_count_q;
  assign weights_out = weights_q;
  assign valid_out   = valid_q;
  assign load_err    = load_err_q;

  always_comb begin
    accept  = valid_in && !full;
    commit  = accept && (tap_cnt_q == LAST_TAP);
    do_load = load_weights && !empty;
    pop     = do_load && !replay_mode;
    // A mode switch restarts replay from the head, even for a load issued that cycle.
    eff_offset = (replay_mode != mode_q) ? '0 : offset_q;
    rd_idx     = head_q + eff_offset;

    commit_set = '0;
    for (int i = 0; i < KERNEL_SIZE - 1; i++) commit_set[i*DATA_WIDTH +: DATA_WIDTH] = coll_q[i];
    commit_set[(KERNEL_SIZE-1)*DATA_WIDTH +: DATA_WIDTH] = in;

    for (int i = 0; i < KERNEL_SIZE - 1; i++) begin
      coll_d[i] = coll_q[i];
      if (accept && tap_cnt_q == TAP_CNT_WIDTH'(i)) coll_d[i] = in;
    end
    for (int s = 0; s < NUM_SETS; s++) begin
      bank_d[s] = bank_q[s];
      if (commit && wr_ptr_q == SET_ADDR_WIDTH'(s)) bank_d[s] = commit_set;
    end

    tap_cnt_d = tap_cnt_q;
    if (commit)      tap_cnt_d = '0;
    else if (accept) tap_cnt_d = tap_cnt_q + TAP_ONE;

    wr_ptr_d = commit ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    head_d   = pop ? head_q + PTR_ONE : head_q;

    set_count_d = set_count_q;
    if (commit && !pop)      set_count_d = set_count_q + CNT_ONE;
    else if (pop && !commit) set_count_d = set_count_q - CNT_ONE;

    // Wrap uses the pre-commit count so a set landing this cycle joins the next pass.
    offset_d = eff_offset;
    if (do_load && replay_mode)
      offset_d = ((CNT_W'(eff_offset) + CNT_ONE) >= set_count_q) ? '0 : eff_offset + PTR_ONE;

    mode_d     = replay_mode;
    weights_d  = do_load ? bank_q[rd_idx] : weights_q;
    valid_d    = do_load;
    load_err_d = load_weights && empty;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tap_cnt_q   <= '0;
      wr_ptr_q    <= '0;
      head_q      <= '0;
      offset_q    <= '0;
      set_count_q <= '0;
      for (int i = 0; i < KERNEL_SIZE - 1; i++) coll_q[i] <= '0;
      weights_q   <= '0;
      valid_q     <= 1'b0;
      load_err_q  <= 1'b0;
      mode_q      <= 1'b0;
    end else begin
      tap_cnt_q   <= tap_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      head_q      <= head_d;
      offset_q    <= offset_d;
      set_count_q <= set_count_d;
      coll_q      <= coll_d;
      weights_q   <= weights_d;
      valid_q     <= valid_d;
      load_err_q  <= load_err_d;
      mode_q      <= mode_d;
    end
  end

  // Bank contents are pure data; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    bank_q <= bank_d;
  end

endmodule

// File: doc/conv_kxk_weight_bank.md
Name: conv_kxk_weight_bank

Overview:
- Parametrised weight store that feeds a KxK convolution engine.
- Deserialises a serial weight stream into complete kernel sets of KERNEL_SIZE taps and holds up to NUM_SETS sets in a register bank.
- Presents one full set in parallel to the MAC array on each load request.
- Two read modes: FIFO (each set is consumed on read) and replay (stored sets cycle round-robin without being consumed), so filters can be reused across image tiles.

Parameters:
- DATA_WIDTH, 32, width of one weight word.
- KERNEL_SIZE, 9, taps per set (K*K; 9 for 3x3, 25 for 5x5).
- TAP_CNT_WIDTH, 4, width of the tap counter; must be at least clog2(KERNEL_SIZE).
- NUM_SETS, 4, depth of the bank in sets; power of two.
- SET_ADDR_WIDTH, 2, clog2(NUM_SETS).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- valid_in  in  1  qualifies in.
- in  in  DATA_WIDTH  serial weight word; the first word of a set is tap 0.
- in_ready  out  1  high when a word can be accepted; equals ~full.
- load_weights  in  1  request the next set onto weights_out.
- replay_mode  in  1  0 = FIFO read, 1 = round-robin replay.
- weights_out  out  KERNEL_SIZE*DATA_WIDTH  parallel set; tap i is at bits [i*DATA_WIDTH +: DATA_WIDTH].
- valid_out  out  1  one-cycle pulse when weights_out is updated.
- load_err  out  1  one-cycle pulse when a load is requested while the bank is empty.
- set_count  out  SET_ADDR_WIDTH+1  number of stored sets.
- full  out  1  set_count == NUM_SETS.
- empty  out  1  set_count == 0.

Behaviour:
- Clock and reset: clk; reset is synchronous, active-high.
- Reset values: set_count 0, write, head and replay-offset pointers 0, tap counter 0, collector cleared, weights_out 0, valid_out 0, load_err 0.
- Reset mid-collection discards any partial set.
- Word acceptance: a word is accepted when valid_in && in_ready. The accepted word goes into collector slot tap_cnt and tap_cnt increments.
- Commit: on the edge that accepts word KERNEL_SIZE-1, the whole set (the KERNEL_SIZE-1 collected words plus the current word) is written to bank[wr_ptr]. On the same edge wr_ptr increments (wrapping modulo NUM_SETS), set_count increments and tap_cnt returns to 0.
- A committed set is loadable on the next cycle.
- valid_in while in_ready=0 is ignored: no counter or data change.
- full cannot rise mid-collection, because only a commit increments set_count.
- Load in FIFO mode: load_weights with empty=0 registers bank[head] into weights_out. On the next edge valid_out=1, head increments (wrapping) and set_count decrements.
- Load in replay mode: load_weights with empty=0 registers bank[head+offset]. offset increments and wraps to 0 when offset+1 == set_count. set_count and head are unchanged.
- A change of replay_mode resets offset to 0 on the following edge.
- Load latency: one cycle from load_weights to valid_out and new weights_out.
- weights_out holds its value between loads.
- Empty load: load_weights with empty=1 pulses load_err for one cycle. weights_out and valid_out are unchanged (valid_out stays 0).
- Simultaneous commit and FIFO pop: set_count is unchanged and both pointers advance.
- A pop when full re-raises in_ready on the next cycle.
- Commit and replay load in the same cycle: the read uses the pre-commit set_count for wrapping.
- load_weights held high loads every cycle; each load follows the rules above.

Test Plan:
- DATA_WIDTH=32, KERNEL_SIZE=9, NUM_SETS=4. Send words 0x10..0x18, then pulse load_weights in FIFO mode -> one cycle later valid_out=1, tap0=0x10, tap8=0x18, and set_count goes 1 -> 0.
- Commit 4 sets A..D -> full=1, in_ready=0; 9 further words are ignored; then 4 FIFO loads -> A, B, C, D, empty=1, and the ignored words never appear.
- load_weights with the bank empty -> load_err=1 for exactly one cycle, weights_out unchanged, valid_out=0.
- replay_mode=1 with sets A and B stored, 5 loads -> A, B, A, B, A; set_count stays 2. Then switch to FIFO and load -> A is popped and set_count=1.
- set_count=3, with the 9th word of set D accepted in the same cycle as a FIFO pop -> set_count stays 3, and a subsequent load order continues correctly through D.
- Reset asserted after 5 words of a set -> set_count=0, and the next 9 words 0x20..0x28 form one set with tap0=0x20.
